// File: rtl/mult_control.sv
// Control FSM for the 8-bit signed add-shift multiplier: clear/load, then WIDTH
// add/shift iterations with a subtract on the last one, then hold until Run drops.
module mult_control #(
  parameter int WIDTH = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic ClrA,
  output logic Ld_A,
  output logic Fn,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, CLRA, ADD, SHIFT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          armed;
  logic          last;

  assign last = (cnt == CW'(WIDTH - 1));

  // armed masks the combinational Clr_Ld on the first cycle out of reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    Clr_Ld    = 1'b0;
    ClrA      = 1'b0;
    Ld_A      = 1'b0;
    Fn        = 1'b0;
    Shift     = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Run)                        state_nxt = CLRA;
        else if (ClearA_LoadB && armed) Clr_Ld    = 1'b1;
      end
      CLRA: begin
        ClrA      = 1'b1;
        Busy      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ADD;
      end
      ADD: begin
        Busy      = 1'b1;
        Ld_A      = M;
        Fn        = last;  // final partial product carries negative weight
        state_nxt = SHIFT;
      end
      SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        if (last) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: drives a behavioural X/A/B datapath from the FSM strobes,
// checks every output per cycle against the timing rules and products against arithmetic.
module tb_mult_control;
  localparam int W = 8;
  localparam int H = 2 * W + 2;

  logic Clk = 1'b0, Reset = 1'b0, Run = 1'b0, ClearA_LoadB = 1'b0;
  logic M, Clr_Ld, ClrA, Ld_A, Fn, Shift, Busy, Done;

  int n_chk = 0, n_err = 0;

  mult_control #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(Clr_Ld), .ClrA(ClrA), .Ld_A(Ld_A), .Fn(Fn), .Shift(Shift),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // datapath harness: X:A:B chain, switches sw, 9-bit signed adder
  logic [7:0] sw = 8'h00, dp_a = 8'h00, dp_b = 8'h00;
  logic       dp_x = 1'b0;
  logic [8:0] sum9;
  logic [6:0] outs;

  assign M    = dp_b[0];
  assign sum9 = Fn ? ({dp_a[7], dp_a} - {sw[7], sw}) : ({dp_a[7], dp_a} + {sw[7], sw});
  assign outs = {Clr_Ld, ClrA, Ld_A, Fn, Shift, Busy, Done};

  always @(posedge Clk) begin
    if (Clr_Ld) begin
      dp_x <= 1'b0; dp_a <= 8'h00; dp_b <= sw;
    end else if (ClrA) begin
      dp_x <= 1'b0; dp_a <= 8'h00;
    end else if (Ld_A) begin
      dp_x <= sum9[8]; dp_a <= sum9[7:0];
    end else if (Shift) begin
      dp_a <= {dp_x, dp_a[7:1]};
      dp_b <= {dp_a[0], dp_b[7:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic run, input logic calb);
    @(posedge Clk);
    #1;
    Run = run;
    ClearA_LoadB = calb;
    #1;
  endtask

  task automatic load_b(input logic [7:0] b, input int n);
    sw = b;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1);
      check("clr_ld", 32'(outs), 32'(7'b1000000));
    end
    step(1'b0, 1'b0);
    check("idle_after_load", 32'(outs), 32'd0);
  endtask

  // Run high during cycles 0..r-1; cycle k is the k-th cycle after edge t0.
  // abort_k > 0 asserts Reset right after checking cycle abort_k.
  task automatic run_mult(input logic [7:0] s, input int r, input int abort_k);
    logic [7:0]  b;
    logic [6:0]  e;
    logic [15:0] pe;
    int          last, p, i;
    logic        lda, fn, sh;
    b    = dp_b;
    sw   = s;
    last = (r > H) ? r : H;
    step(1'b1, 1'($urandom_range(0, 1)));
    check("run_priority", 32'(outs), 32'd0);
    for (int k = 1; k <= last + 2; k++) begin
      step(1'(k < r), (k <= last) ? 1'($urandom_range(0, 1)) : 1'b0);
      lda = 1'b0; fn = 1'b0; sh = 1'b0;
      if (k >= 2 && k <= 2 * W + 1) begin
        i = (k - 2) / 2;
        if (k % 2 == 0) begin
          lda = b[i];
          fn  = (i == W - 1);
        end else begin
          sh = 1'b1;
        end
      end
      e = {1'b0, 1'(k == 1), lda, fn, sh, 1'(k >= 1 && k <= 2 * W + 1),
           1'(k >= H && k <= last)};
      check($sformatf("cyc%0d", k), 32'(outs), 32'(e));
      if (abort_k > 0 && k == abort_k) begin
        Reset = 1'b0;
        #1;
        check("rst_async", 32'(outs), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        ClearA_LoadB = 1'b1;
        Run = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check("rst_first_cycle", 32'(outs), 32'd0);
        @(posedge Clk);
        #1;
        check("rst_rearm", 32'(outs), 32'(7'b1000000));
        ClearA_LoadB = 1'b0;
        return;
      end
    end
    p  = $signed(b) * $signed(s);
    pe = p[15:0];
    check($sformatf("product_%02h_x_%02h", b, s), 32'({dp_a, dp_b}), 32'(pe));
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("reset_outs", 32'(outs), 32'd0);
    #1;
    Reset = 1'b1;
    #1;
    check("first_cycle", 32'(outs), 32'd0);

    load_b(8'hC5, 3);  run_mult(8'h07, H + 3, 0);
    load_b(8'h01, 1);  run_mult(8'hFF, H + 1, 0);
    load_b(8'hFF, 2);  run_mult(8'hFF, 1, 0);
    load_b(8'hFE, 1);  run_mult(8'hCA, H, 0);
    load_b(8'h00, 1);  run_mult(8'h5A, 3, 0);
    run_mult(8'h03, H + 2, 0);  // reuses the low product byte as B
    load_b(8'hFF, 1);  run_mult(8'h11, 40, 8);
    load_b(8'h80, 1);  run_mult(8'h80, H + 4, 0);

    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 3) != 0) load_b(8'($urandom), $urandom_range(1, 3));
      run_mult(8'($urandom), $urandom_range(1, H + 5), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
